clk_ratio_meter: RTL and testbench



---
 rtl/clk_ratio_meter.sv | 154 +++++++++++++++
 tb/tb_clk_ratio_meter.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/clk_ratio_meter.sv
// clk_ratio_meter: samples a divided clock on the reference clock and reports
// its high/low phase lengths, lock on a stable ratio, ratio-change errors and stalls.
module clk_ratio_meter #(
  parameter int CNT_WIDTH  = 16,
  parameter int LOCK_COUNT = 4,
  parameter int TIMEOUT    = 1000
) (
  input  logic                 I_ref_clk,
  input  logic                 I_rst,
  input  logic                 I_meas_en,
  input  logic                 I_clk_in,
  output logic [CNT_WIDTH-1:0] O_high_len,
  output logic [CNT_WIDTH-1:0] O_low_len,
  output logic                 O_valid,
  output logic                 O_locked,
  output logic                 O_err,
  output logic                 O_stall
);

  localparam logic [CNT_WIDTH-1:0] CNT_ONE   = CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] TIMEOUT_V = CNT_WIDTH'(TIMEOUT);
  localparam logic [3:0]           LOCK_MAX  = 4'(LOCK_COUNT);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SYNC,
    ST_MEASURE
  } state_t;

  state_t               state;
  state_t               state_nxt;

  logic                 sync1;
  logic                 sync2;
  logic                 prev;
  logic                 edge_det;

  logic [CNT_WIDTH-1:0] cnt;
  logic                 cnt_max;
  logic [CNT_WIDTH-1:0] prev_len;
  logic                 has_prev;
  logic [3:0]           match_cnt;
  logic [3:0]           match_inc;
  logic                 same_len;

  logic                 clr;
  logic                 capture;
  logic                 stall_hit;
  logic                 sync_edge;

  assign edge_det  = sync2 != prev;
  assign cnt_max   = cnt == TIMEOUT_V;
  assign same_len  = cnt == prev_len;
  assign match_inc = (match_cnt == LOCK_MAX) ? match_cnt : match_cnt + 4'd1;

  // Synchronize the asynchronous divided clock and keep one delayed copy for edge detection
  always_ff @(posedge I_ref_clk) begin
    if (I_rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      prev  <= 1'b0;
    end else begin
      sync1 <= I_clk_in;
      sync2 <= sync1;
      prev  <= sync2;
    end
  end

  // State register
  always_ff @(posedge I_ref_clk) begin
    if (I_rst) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic; an edge takes priority over a saturated counter
  always_comb begin
    state_nxt = state;
    if (!I_meas_en) begin
      state_nxt = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE:    state_nxt = ST_SYNC;
        ST_SYNC:    if (edge_det) state_nxt = ST_MEASURE;
        ST_MEASURE: if (!edge_det && cnt_max) state_nxt = ST_SYNC;
        default:    state_nxt = ST_IDLE;
      endcase
    end
  end

  // Per-state control strobes for the measurement datapath
  always_comb begin
    clr       = !I_meas_en || (state == ST_IDLE);
    capture   = I_meas_en && (state == ST_MEASURE) && edge_det;
    sync_edge = I_meas_en && (state == ST_SYNC) && edge_det;
    stall_hit = I_meas_en && (state != ST_IDLE) && !edge_det && cnt_max;
  end

  // Phase counting, length capture, lock tracking and stall flag
  always_ff @(posedge I_ref_clk) begin
    if (I_rst) begin
      cnt        <= '0;
      prev_len   <= '0;
      has_prev   <= 1'b0;
      match_cnt  <= '0;
      O_high_len <= '0;
      O_low_len  <= '0;
      O_valid    <= 1'b0;
      O_locked   <= 1'b0;
      O_err      <= 1'b0;
      O_stall    <= 1'b0;
    end else begin
      O_valid <= capture;
      if (clr) begin
        cnt       <= '0;
        has_prev  <= 1'b0;
        match_cnt <= '0;
        O_locked  <= 1'b0;
        O_err     <= 1'b0;
        O_stall   <= 1'b0;
      end else begin
        if (edge_det)     cnt <= CNT_ONE;
        else if (!cnt_max) cnt <= cnt + CNT_ONE;

        if (stall_hit) begin
          O_stall   <= 1'b1;
          O_locked  <= 1'b0;
          match_cnt <= '0;
          has_prev  <= 1'b0;
        end

        if (sync_edge) O_stall <= 1'b0;

        if (capture) begin
          // sync2 high means a rising edge, which closes a low phase
          if (sync2) O_low_len  <= cnt;
          else       O_high_len <= cnt;
          prev_len <= cnt;
          has_prev <= 1'b1;
          if (has_prev) begin
            if (same_len) begin
              match_cnt <= match_inc;
              O_locked  <= match_inc == LOCK_MAX;
            end else begin
              match_cnt <= '0;
              O_locked  <= 1'b0;
              if (O_locked) O_err <= 1'b1;
            end
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_clk_ratio_meter.sv
// Directed bench for clk_ratio_meter driven by a simple divider model.
module tb_clk_ratio_meter;

  localparam int T = 40;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic        cin;
  logic [15:0] high_len;
  logic [15:0] low_len;
  logic        valid;
  logic        locked;
  logic        err;
  logic        stall;

  int errors = 0;
  int checks = 0;

  // divider model state
  int       cyc    = 0;
  int       ratio  = 4;
  int       ph     = 0;
  bit       div_en = 1'b0;
  logic [3:0] lvl_d = '0;

  clk_ratio_meter #(
    .CNT_WIDTH (16),
    .LOCK_COUNT(4),
    .TIMEOUT   (T)
  ) dut (
    .I_ref_clk (clk),
    .I_rst     (rst),
    .I_meas_en (en),
    .I_clk_in  (cin),
    .O_high_len(high_len),
    .O_low_len (low_len),
    .O_valid   (valid),
    .O_locked  (locked),
    .O_err     (err),
    .O_stall   (stall)
  );

  always #5 clk = ~clk;

  // Divider: toggles every `ratio` ref cycles when enabled; ratio 0 holds the output
  initial begin
    cin = 1'b0;
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      if (div_en && ratio >= 1) begin
        ph++;
        if (ph >= ratio) begin
          cin = ~cin;
          ph  = 0;
        end
      end
      lvl_d = {lvl_d[2:0], cin};
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic wait_valid(input int max, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max; i++) begin
      @(negedge clk);
      if (valid) begin
        ok = 1'b1;
        return;
      end
    end
  endtask

  // Length register updated by the capture observed now (edge launched 3 cycles ago)
  function automatic logic [15:0] cap_len();
    return lvl_d[3] ? low_len : high_len;
  endfunction

  task automatic test_reset();
    rst = 1'b1; en = 1'b0; div_en = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (high_len !== 16'd0) begin errors++; $display("FAIL reset_high: got %0d want 0", high_len); end
    checks++; if (low_len !== 16'd0) begin errors++; $display("FAIL reset_low: got %0d want 0", low_len); end
    checks++; if ({valid, locked, err, stall} !== 4'b0000) begin errors++; $display("FAIL reset_flags: got %b want 0000", {valid, locked, err, stall}); end
    rst = 1'b0;
  endtask

  task automatic test_ratio4();
    bit ok;
    int c0;
    ratio = 4; ph = 0; en = 1'b1;
    repeat (5) @(negedge clk);
    c0 = cyc; div_en = 1'b1;
    wait_valid(30, ok);
    checks++; if (!ok || cyc !== c0 + 11) begin errors++; $display("FAIL r4_first_valid: got cycle %0d want %0d", cyc, c0 + 11); end
    checks++; if (high_len !== 16'd4) begin errors++; $display("FAIL r4_first_len: got %0d want 4", high_len); end
    @(negedge clk);
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL r4_pulse_width: got %b want 0", valid); end
    for (int i = 2; i <= 5; i++) begin
      wait_valid(10, ok);
      checks++; if (!ok || cap_len() !== 16'd4) begin errors++; $display("FAIL r4_len_%0d: got %0d want 4", i, cap_len()); end
      checks++; if (locked !== (i == 5)) begin errors++; $display("FAIL r4_lock_%0d: got %b want %b", i, locked, i == 5); end
    end
    checks++; if (err !== 1'b0 || low_len !== 16'd4) begin errors++; $display("FAIL r4_final: got err=%b low=%0d want err=0 low=4", err, low_len); end
  endtask

  task automatic test_stall();
    bit ok;
    int s;
    div_en = 1'b0;
    for (int i = 1; i <= T; i++) begin
      @(negedge clk);
      if (i == T - 1) begin
        checks++; if (stall !== 1'b0 || locked !== 1'b1) begin errors++; $display("FAIL stall_early: got stall=%b locked=%b want 0 1", stall, locked); end
      end
    end
    checks++; if (stall !== 1'b1 || locked !== 1'b0) begin errors++; $display("FAIL stall_set: got stall=%b locked=%b want 1 0", stall, locked); end
    ph = 0; s = cyc; div_en = 1'b1;
    repeat (6) @(negedge clk);
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL stall_hold: got %b want 1", stall); end
    @(negedge clk);
    checks++; if (stall !== 1'b0 || valid !== 1'b0) begin errors++; $display("FAIL stall_clear: got stall=%b valid=%b want 0 0", stall, valid); end
    wait_valid(10, ok);
    checks++; if (!ok || cyc !== s + 11 || cap_len() !== 16'd4) begin errors++; $display("FAIL stall_recapture: got cycle %0d len %0d want %0d len 4", cyc, cap_len(), s + 11); end
  endtask

  task automatic test_ratio_change();
    bit ok;
    for (int i = 0; i < 4; i++) wait_valid(10, ok);
    checks++; if (locked !== 1'b1) begin errors++; $display("FAIL rc_relock4: got %b want 1", locked); end
    ratio = 3;
    wait_valid(10, ok);
    checks++; if (!ok || cap_len() !== 16'd4 || locked !== 1'b1 || err !== 1'b0) begin errors++; $display("FAIL rc_last4: got len %0d locked %b err %b want 4 1 0", cap_len(), locked, err); end
    wait_valid(10, ok);
    checks++; if (!ok || cap_len() !== 16'd3 || locked !== 1'b0 || err !== 1'b1) begin errors++; $display("FAIL rc_mismatch: got len %0d locked %b err %b want 3 0 1", cap_len(), locked, err); end
    for (int j = 1; j <= 4; j++) begin
      wait_valid(10, ok);
      checks++; if (!ok || cap_len() !== 16'd3 || locked !== (j == 4) || err !== 1'b1) begin errors++; $display("FAIL rc_relock_%0d: got len %0d locked %b err %b want 3 %b 1", j, cap_len(), locked, err, j == 4); end
    end
  endtask

  task automatic test_ratio0();
    int nvalid = 0;
    en = 1'b0; ratio = 0;
    @(negedge clk);
    checks++; if (err !== 1'b0 || locked !== 1'b0 || high_len !== 16'd3) begin errors++; $display("FAIL idle_clear: got err %b locked %b high %0d want 0 0 3", err, locked, high_len); end
    repeat (3) @(negedge clk);
    en = 1'b1;
    for (int i = 1; i <= 2 * T; i++) begin
      @(negedge clk);
      if (valid) nvalid++;
      if (i == T + 1) begin
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL r0_stall_early: got %b want 0", stall); end
      end
      if (i == T + 2) begin
        checks++; if (stall !== 1'b1) begin errors++; $display("FAIL r0_stall_set: got %b want 1", stall); end
      end
    end
    checks++; if (nvalid !== 0 || stall !== 1'b1) begin errors++; $display("FAIL r0_no_valid: got %0d pulses stall %b want 0 1", nvalid, stall); end
  endtask

  task automatic test_meas_drop();
    bit ok;
    ratio = 7; ph = 0;
    for (int i = 1; i <= 5; i++) begin
      wait_valid(40, ok);
      checks++; if (!ok || cap_len() !== 16'd7 || locked !== (i == 5)) begin errors++; $display("FAIL r7_cap_%0d: got len %0d locked %b want 7 %b", i, cap_len(), locked, i == 5); end
    end
    repeat (2) @(negedge clk);
    en = 1'b0;
    @(negedge clk);
    checks++; if ({locked, err, stall} !== 3'b000) begin errors++; $display("FAIL drop_flags: got %b want 000", {locked, err, stall}); end
    checks++; if (high_len !== 16'd7 || low_len !== 16'd7) begin errors++; $display("FAIL drop_hold: got %0d/%0d want 7/7", high_len, low_len); end
    repeat (2) @(negedge clk);
    en = 1'b1;
    wait_valid(40, ok);
    checks++; if (!ok || cap_len() !== 16'd7) begin errors++; $display("FAIL drop_reenable: got len %0d want 7", cap_len()); end
  endtask

  task automatic test_reset_mid();
    rst = 1'b1;
    @(negedge clk);
    checks++; if ({high_len, low_len} !== 32'd0 || {valid, locked, err, stall} !== 4'b0000) begin errors++; $display("FAIL reset_mid: got %0d/%0d %b want 0/0 0000", high_len, low_len, {valid, locked, err, stall}); end
    rst = 1'b0;
  endtask

  task automatic test_back_to_back();
    bit ok;
    ratio = 1; ph = 0;
    wait_valid(20, ok);
    checks++; if (!ok || cap_len() !== 16'd1) begin errors++; $display("FAIL len1_first: got len %0d want 1", cap_len()); end
    for (int j = 2; j <= 5; j++) begin
      @(negedge clk);
      checks++; if (valid !== 1'b1 || cap_len() !== 16'd1 || locked !== (j == 5)) begin errors++; $display("FAIL len1_b2b_%0d: got valid %b len %0d locked %b want 1 1 %b", j, valid, cap_len(), locked, j == 5); end
    end
  endtask

  initial begin
    rst = 1'b1; en = 1'b0;
    test_reset();
    test_ratio4();
    test_stall();
    test_ratio_change();
    test_ratio0();
    test_meas_drop();
    test_reset_mid();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
